// File: rtl/lc4_load_issue_sched.sv
// Load-pipe issue scheduler: collapsing age-ordered queue with tag wakeup and oldest-ready select.
// Optional same-cycle wakeup bypass into select: define LC4_LDQ_WAKE_BYPASS_EN.
module lc4_load_issue_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [15:0]                  enq_insn,
    input  logic [15:0]                  enq_pc,
    input  logic [TAG_W-1:0]             enq_src1_tag,
    input  logic [TAG_W-1:0]             enq_src2_tag,
    input  logic                         enq_src1_rdy,
    input  logic                         enq_src2_rdy,
    input  logic [TAG_W-1:0]             enq_dst_tag,
    input  logic                         wake_valid,
    input  logic [TAG_W-1:0]             wake_tag,
    input  logic                         flush,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [15:0]                  iss_insn,
    output logic [15:0]                  iss_pc,
    output logic [TAG_W-1:0]             iss_src1_tag,
    output logic [TAG_W-1:0]             iss_src2_tag,
    output logic [TAG_W-1:0]             iss_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0]      insn;
        logic [15:0]      pc;
        logic [TAG_W-1:0] src1_tag;
        logic             src1_rdy;
        logic [TAG_W-1:0] src2_tag;
        logic             src2_rdy;
        logic [TAG_W-1:0] dst_tag;
    } entry_t;

    // Entry validity is implied by position: index i is valid iff i < count_q.
    entry_t         q_q [DEPTH];
    entry_t         q_d [DEPTH];
    entry_t         iss_q, iss_d;
    entry_t         enq_entry;
    logic           iss_valid_q, iss_valid_d;
    logic [CW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] elig;
    logic           any_elig;
    int             sel_idx;
    logic           do_load;
    logic           enq_fire;

    assign enq_ready = (count_q < CW'(DEPTH));
    assign enq_fire  = enq_valid && enq_ready;
    assign do_load   = (!iss_valid_q || iss_ready) && any_elig;

    always_comb begin
        elig     = '0;
        any_elig = 1'b0;
        sel_idx  = 0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
`ifdef LC4_LDQ_WAKE_BYPASS_EN
            elig[i] = (i < int'(count_q))
                   && (q_q[i].src1_rdy || (wake_valid && (q_q[i].src1_tag == wake_tag)))
                   && (q_q[i].src2_rdy || (wake_valid && (q_q[i].src2_tag == wake_tag)));
`else
            elig[i] = (i < int'(count_q)) && q_q[i].src1_rdy && q_q[i].src2_rdy;
`endif
            if (elig[i]) begin
                sel_idx  = i;
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        enq_entry          = '0;
        enq_entry.insn     = enq_insn;
        enq_entry.pc       = enq_pc;
        enq_entry.src1_tag = enq_src1_tag;
        enq_entry.src2_tag = enq_src2_tag;
        enq_entry.dst_tag  = enq_dst_tag;
        enq_entry.src1_rdy = enq_src1_rdy || (wake_valid && (enq_src1_tag == wake_tag));
        enq_entry.src2_rdy = enq_src2_rdy || (wake_valid && (enq_src2_tag == wake_tag));
    end

    always_comb begin
        q_d         = q_q;
        count_d     = count_q;
        iss_d       = iss_q;
        iss_valid_d = iss_valid_q;

        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
            if (do_load && (i >= sel_idx)) q_d[i] = q_q[i + 1];
        end
        // Wakeup is applied after compaction so shifted entries see it too.
        if (wake_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (q_d[i].src1_tag == wake_tag) q_d[i].src1_rdy = 1'b1;
                if (q_d[i].src2_tag == wake_tag) q_d[i].src2_rdy = 1'b1;
            end
        end

        if (do_load) count_d = count_q - CW'(1);
        if (enq_fire) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == int'(count_d)) q_d[i] = enq_entry;
            end
            count_d = count_d + CW'(1);
        end

        if (do_load) begin
            iss_valid_d = 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == sel_idx) iss_d = q_q[i];
            end
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end

        if (flush) begin
            count_d     = '0;
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) q_q[i] <= '0;
            iss_q       <= '0;
            iss_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            q_q         <= q_d;
            iss_q       <= iss_d;
            iss_valid_q <= iss_valid_d;
            count_q     <= count_d;
        end
    end

    assign iss_valid    = iss_valid_q;
    assign iss_insn     = iss_q.insn;
    assign iss_pc       = iss_q.pc;
    assign iss_src1_tag = iss_q.src1_tag;
    assign iss_src2_tag = iss_q.src2_tag;
    assign iss_dst_tag  = iss_q.dst_tag;
    assign count        = count_q;

endmodule

// File: doc/lc4_load_issue_sched.md
# lc4_load_issue_sched

Issue scheduler for the LC4 out-of-order core's load pipe. It buffers decoded load/store-address micro-ops from dispatch and tracks readiness of each op's two source physical registers through result-tag wakeups. Each cycle it selects the oldest ready op and presents it, with a valid/ready handshake, to the load0 execute stage. That stage computes the ALU/PC+1 result and the destination from the instruction.

## Interface
- DEPTH, 4: queue entries (2..8).
- TAG_W, 6: physical register tag width.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enq_valid  in  1  dispatch offers an op.
- enq_ready  out  1  queue can accept; equals (count < DEPTH).
- enq_insn  in  16  LC4 instruction.
- enq_pc  in  16  instruction PC.
- enq_src1_tag, enq_src2_tag  in  TAG_W  source physical tags.
- enq_src1_rdy, enq_src2_rdy  in  1  source already available at dispatch.
- enq_dst_tag  in  TAG_W  destination physical tag.
- wake_valid  in  1  result broadcast this cycle.
- wake_tag  in  TAG_W  broadcast tag.
- flush  in  1  squash all queued and pending ops.
- iss_valid  out  1  issue register holds an op.
- iss_ready  in  1  load0 stage accepts.
- iss_insn, iss_pc  out  16  issued op fields.
- iss_src1_tag, iss_src2_tag, iss_dst_tag  out  TAG_W  issued tags, used for regfile read and writeback.
- count  out  $clog2(DEPTH+1)  valid queue entries, excluding the issue register.

## Operation
- Collapsing age-ordered queue. Entry 0 is the oldest. New ops are written at index `count` after any same-edge removal is compacted.
- Entry state: valid, insn, pc, src1_tag/rdy, src2_tag/rdy, dst_tag.
- Enqueue fires on enq_valid && enq_ready. enq_ready ignores a same-cycle issue, so a full queue never accepts, even while issuing.
- Wakeup: when wake_valid is high, every valid entry whose srcN_tag == wake_tag sets srcN_rdy on the edge. An enqueuing op whose src tag matches wake_tag is stored ready.
- Entry eligibility: valid && src1_rdy && src2_rdy.
- Select: the lowest-index eligible entry.
- Issue register load condition: (!iss_valid || iss_ready) and an eligible entry exists.
  - On load, the selected entry moves into the issue register and is removed.
  - Younger entries shift down one index.
- If iss_valid && iss_ready and no entry is eligible, iss_valid clears.
- While iss_valid && !iss_ready, all iss_* outputs hold stable.
- Flush: on the edge, all entries are invalidated, count becomes 0 and iss_valid becomes 0. Flush has priority over enqueue, wakeup and issue in the same cycle.
- Readiness is tracked purely by tags; the instruction is never decoded. Non-load ops dispatched here are issued identically.

## Timing
- Reset (async, rst_n low): all entries invalid; count=0; iss_valid=0; iss_insn/iss_pc=16'h0000; iss tags=0; enq_ready=1.
- Deassertion is sampled at the next edge; no stimulus is required during reset.
- An op enqueued ready at edge E0 is selectable in the cycle after E0. It loads into the issue register at E1, so iss_valid=1 after E1 (2-edge latency).
- An op made ready by wakeup at edge E0 is likewise issued at E1.
- Back-to-back ready ops issue one per cycle while iss_ready=1.
- Enqueue, issue and wakeup in the same cycle are all applied on one edge. The wakeup also applies to the new entry and to the shifted entries.
- A wakeup matching the op already in the issue register has no effect.
- DEPTH entries plus the issue register gives at most DEPTH+1 ops in flight.

## Configuration
- LC4_LDQ_WAKE_BYPASS_EN defined:
  - Eligibility also counts a source as ready if wake_valid && srcN_tag == wake_tag in the current cycle.
  - An entry can therefore move into the issue register on the same edge its wakeup arrives, one cycle earlier than the base behaviour.
  - The bypass does not apply to an op being enqueued in that cycle.
- Not defined: readiness uses stored rdy bits only; the wakeup-to-issue latency is 1 edge after the wakeup edge.

## Test plan
- Reset, then enqueue insn=16'h6283, pc=16'h0010, both sources ready -> iss_valid=1 two edges later with iss_insn=16'h6283, iss_pc=16'h0010; count returns to 0.
- Enqueue A (src1 tag 5, not ready), then B (ready) -> B issues first. Wake tag 5 -> A issues next. With the macro defined, A issues one cycle earlier.
- Hold iss_ready=0 and enqueue 4 ready ops -> one op in the issue register, count=3, enq_ready=1. Enqueue a 5th -> count=4, enq_ready=0, iss_* stable. Release iss_ready -> ops issue in order, one per cycle.
- Full queue with issue firing and enq_valid=1 in the same cycle -> no enqueue; count decrements to 3.
- Enqueue an op with src2 tag 9 in the same cycle wake_tag=9 -> op stored ready and issues on schedule.
- With 3 entries queued and iss_valid=1, assert flush together with enq_valid -> after the edge count=0, iss_valid=0 and the new op is dropped. Assert rst_n low mid-stream -> outputs reach reset values immediately, without waiting for a clock edge.
